// File: rtl/x_muldiv_if.sv
// rtl/x_muldiv_if.sv - execute-stage <-> multiply/divide unit signal bundle
interface x_muldiv_if #(
    parameter int WIDTH = 32
);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] rs_d;
    logic [WIDTH-1:0] rt_d;
    logic             flush;
    logic             hi_we;
    logic             lo_we;
    logic [WIDTH-1:0] wdata;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;

    modport master (
        output start, op, rs_d, rt_d, flush, hi_we, lo_we, wdata,
        input  busy, done, hi, lo
    );

    modport slave (
        input  start, op, rs_d, rt_d, flush, hi_we, lo_we, wdata,
        output busy, done, hi, lo
    );
endinterface

// File: rtl/x_muldiv.sv
// rtl/x_muldiv.sv - iterative MULT/MULTU/DIV/DIVU unit owning the HI/LO registers
// Operands are reduced to magnitudes at launch; signs are reapplied in the FIX cycle.
module x_muldiv #(
    parameter int WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst,
    x_muldiv_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;

    logic [1:0]         state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               div0_q, div0_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               done_q, done_d;

    logic               signed_op, rs_neg, rt_neg, div0_in;
    logic [WIDTH-1:0]   rs_abs, rt_abs;
    logic [WIDTH:0]     mul_sum, rem_sh, diff;
    logic [2*WIDTH-1:0] mul_next, div_next, prod_fix;

    // op[0]=0 selects the signed variants, op[1]=1 selects divide
    assign signed_op = ~bus.op[0];
    assign rs_neg    = signed_op & bus.rs_d[WIDTH-1];
    assign rt_neg    = signed_op & bus.rt_d[WIDTH-1];
    assign rs_abs    = rs_neg ? -bus.rs_d : bus.rs_d;
    assign rt_abs    = rt_neg ? -bus.rt_d : bus.rt_d;
    assign div0_in   = bus.op[1] & (bus.rt_d == '0);

    assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, m_q} : '0);
    assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

    // Restoring step: the borrow bit diff[WIDTH] means the trial subtract failed
    assign rem_sh   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    assign diff     = rem_sh - {1'b0, m_q};
    assign div_next = diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                  : {diff[WIDTH-1:0],  acc_q[WIDTH-2:0], 1'b1};

    assign prod_fix = neg_lo_q ? -acc_q : acc_q;

    always_comb begin
        state_d  = state_q;
        is_div_d = is_div_q;
        div0_d   = div0_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        m_d      = m_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (bus.hi_we) hi_d = bus.wdata;
                if (bus.lo_we) lo_d = bus.wdata;
                if (bus.start && !bus.flush) begin
                    state_d  = S_RUN;
                    cnt_d    = '0;
                    is_div_d = bus.op[1];
                    div0_d   = div0_in;
                    if (bus.op[1]) begin
                        m_d      = rt_abs;
                        acc_d    = {{WIDTH{1'b0}}, rs_abs};
                        neg_lo_d = (rs_neg ^ rt_neg) & ~div0_in;
                        neg_hi_d = rs_neg;
                    end else begin
                        m_d      = rs_abs;
                        acc_d    = {{WIDTH{1'b0}}, rt_abs};
                        neg_lo_d = rs_neg ^ rt_neg;
                        neg_hi_d = rs_neg ^ rt_neg;
                    end
                end
            end
            S_RUN: begin
                if (bus.flush) begin
                    state_d = S_IDLE;
                end else begin
                    acc_d = is_div_q ? div_next : mul_next;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CW'(WIDTH - 1)) state_d = S_FIX;
                end
            end
            S_FIX: begin
                state_d = S_IDLE;
                if (!bus.flush) begin
                    done_d = 1'b1;
                    if (is_div_q) begin
                        lo_d = div0_q   ? '1 : (neg_lo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0]);
                        hi_d = neg_hi_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
                    end else begin
                        hi_d = prod_fix[2*WIDTH-1:WIDTH];
                        lo_d = prod_fix[WIDTH-1:0];
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            is_div_q <= 1'b0;
            div0_q   <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            m_q      <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            is_div_q <= is_div_d;
            div0_q   <= div0_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            m_q      <= m_d;
            acc_q    <= acc_d;
            cnt_q    <= cnt_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            done_q   <= done_d;
        end
    end

    assign bus.busy = (state_q != S_IDLE);
    assign bus.done = done_q;
    assign bus.hi   = hi_q;
    assign bus.lo   = lo_q;
endmodule
